// File: rtl/sched_pkg.sv
// Shared opcode encodings, scheduler states and instruction width for the instruction scheduler.
package sched_pkg;
  localparam int INSTR_W = 64;

  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_COMPUTE   = 5'b00001;
  localparam logic [4:0] OP_COMPUTE_I = 5'b00010;
  localparam logic [4:0] OP_ACC_WB    = 5'b00011;
  localparam logic [4:0] OP_LD_INP    = 5'b00100;
  localparam logic [4:0] OP_LD_WT     = 5'b00101;
  localparam logic [4:0] OP_OUT_SEND  = 5'b00110;
  localparam logic [4:0] OP_ACC_RST   = 5'b00111;
  localparam logic [4:0] OP_HALT      = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_COMPUTE,
    ST_WAIT_OUT,
    ST_HALT
  } state_t;
endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO; pop_data shows the head combinationally, one-edge write-to-read.
// Backpressure: full blocks further pushes, pop on empty is ignored; push+pop together keeps count.
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_scheduler.sv
// Buffers host instructions and issues one per cycle to the decoder, stalling for compute drain, output sends and halt.
// Latency: push-to-issue is two edges (no bypass); backpressure: host_ready drops when the FIFO is full.
module instr_scheduler
  import sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int COMPUTE_LAT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [63:0]                       host_instr,
  input  logic                              host_valid,
  output logic                              host_ready,
  input  logic                              out_done,
  input  logic                              resume,
  output logic [63:0]                       instr_out,
  output logic                              busy,
  output logic                              halted,
  output logic                              illegal_op,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int LW = $clog2(COMPUTE_LAT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [LW-1:0]      lat_cnt;
  logic [LW-1:0]      lat_cnt_nxt;
  logic [INSTR_W-1:0] head;
  logic [INSTR_W-1:0] instr_nxt;
  logic               illegal_nxt;
  logic               pop;
  logic               empty;
  logic               full;
  logic [4:0]         op;

  assign op         = head[4:0];
  assign host_ready = !full;

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (host_valid),
    .push_data (host_instr),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      instr_out  <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      instr_out  <= instr_nxt;
      illegal_op <= illegal_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          case (op)
            OP_COMPUTE, OP_COMPUTE_I: begin
              state_nxt   = ST_WAIT_COMPUTE;
              lat_cnt_nxt = LW'(COMPUTE_LAT);
            end
            OP_OUT_SEND: state_nxt = ST_WAIT_OUT;
            OP_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_IDLE;
          endcase
        end
      end
      // Leaving on the edge where the count reaches zero puts the next issue COMPUTE_LAT+1 edges after the compute.
      ST_WAIT_COMPUTE: begin
        lat_cnt_nxt = lat_cnt - LW'(1);
        if (lat_cnt == LW'(1)) state_nxt = ST_IDLE;
      end
      ST_WAIT_OUT: if (out_done) state_nxt = ST_IDLE;
      ST_HALT:     if (resume)   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    instr_nxt   = '0;
    illegal_nxt = 1'b0;
    if (state == ST_IDLE && !empty) begin
      pop = 1'b1;
      case (op)
        OP_COMPUTE, OP_COMPUTE_I, OP_ACC_WB, OP_LD_INP,
        OP_LD_WT, OP_OUT_SEND, OP_ACC_RST: instr_nxt = head;
        OP_NOP, OP_HALT:                   instr_nxt = '0;
        default:                           illegal_nxt = 1'b1;
      endcase
    end
  end

  assign busy   = (state == ST_WAIT_COMPUTE) || (state == ST_WAIT_OUT);
  assign halted = (state == ST_HALT);
endmodule
